// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//
// Purpose:
//   A bank of CH independent switch/button debouncers. Each channel has its own
//   four-state FSM (ZERO, WAIT1, ONE, WAIT0) and its own N-bit down counter. A
//   new input level must be seen for 2^N consecutive clk edges before the
//   debounced level follows it. Any opposite sample during a wait aborts the
//   wait; the next wait starts again from a full reload.
//
// Optional feature (compile-time macro DEBOUNCE_BANK_LONGPRESS_EN):
//   Adds an LP_N-bit saturating up counter per channel. It counts while the
//   debounced level is high and pulses long_tick once when it saturates. When
//   the macro is undefined, neither the long_tick port nor the counters exist.
//
// Parameters:
//   CH    number of channels (1..32)
//   N     debounce counter width; settle time is 2^N clk cycles
//   LP_N  long-press counter width (only used with the long-press feature)
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous, active-high reset
//   sw         raw switch inputs, already synchronous to clk
//   en         per-channel enable; 0 holds the channel idle at level 0
//   db_level   registered debounced level per channel
//   rise_tick  registered one-cycle pulse on a debounced 0->1 transition
//   fall_tick  registered one-cycle pulse on a debounced 1->0 transition
//   any_tick   OR of every rise_tick and fall_tick bit
//   long_tick  registered one-cycle long-press pulse per channel
//              (only with DEBOUNCE_BANK_LONGPRESS_EN)
// -----------------------------------------------------------------------------
module debounce_bank #(
  parameter int CH   = 4,
  parameter int N    = 21,
  parameter int LP_N = 26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  input  logic [CH-1:0] en,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] rise_tick,
  output logic [CH-1:0] fall_tick,
  output logic          any_tick
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
  ,
  output logic [CH-1:0] long_tick
`endif
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  // Reject configurations the bank is not meant to be built with.
  if (CH < 1 || CH > 32 || N < 1 || LP_N < 1) begin : g_param_check
    $error("debounce_bank: illegal parameter value");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch

    state_t       state;
    state_t       state_next;
    logic [N-1:0] cnt;
    logic [N-1:0] cnt_next;
    logic [N-1:0] cnt_dec;
    logic         db_q;
    logic         rise_q;
    logic         fall_q;
    logic         rise_next;
    logic         fall_next;
    logic         level_next;

    // The wait ends on the edge whose decremented value reaches zero, so a
    // reload of all ones plus 2^N-1 decrements gives exactly 2^N edges
    // from the first edge that samples the new input level.
    assign cnt_dec    = cnt - 1'b1;
    assign level_next = (state_next == ONE) || (state_next == WAIT0);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= ZERO;
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        state  <= state_next;
        cnt    <= cnt_next;
        db_q   <= level_next;
        rise_q <= rise_next;
        fall_q <= fall_next;
      end
    end

    // A disabled channel is pulled straight to ZERO with a cleared counter;
    // leaving ONE this way is deliberately not reported as a falling edge.
    // Counters are parked at zero outside the wait states.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      if (!en[i]) begin
        state_next = ZERO;
        cnt_next   = '0;
      end else begin
        case (state)
          ZERO: begin
            if (sw[i]) begin
              state_next = WAIT1;
              cnt_next   = '1;
            end
          end
          WAIT1: begin
            if (!sw[i]) begin
              state_next = ZERO;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_dec;
              if (cnt_dec == '0) begin
                state_next = ONE;
                rise_next  = 1'b1;
              end
            end
          end
          ONE: begin
            if (!sw[i]) begin
              state_next = WAIT0;
              cnt_next   = '1;
            end
          end
          WAIT0: begin
            if (sw[i]) begin
              state_next = ONE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_dec;
              if (cnt_dec == '0) begin
                state_next = ZERO;
                fall_next  = 1'b1;
              end
            end
          end
          default: begin
            state_next = ZERO;
            cnt_next   = '0;
          end
        endcase
      end
    end

    assign db_level[i]  = db_q;
    assign rise_tick[i] = rise_q;
    assign fall_tick[i] = fall_q;

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    logic [LP_N-1:0] lp_cnt;
    logic [LP_N-1:0] lp_next;
    logic [LP_N-1:0] lp_inc;
    logic            long_q;
    logic            long_next;

    assign lp_inc = lp_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lp_cnt <= '0;
        long_q <= 1'b0;
      end else begin
        lp_cnt <= lp_next;
        long_q <= long_next;
      end
    end

    // Counting restarts whenever ONE is (re)entered and runs through ONE and
    // WAIT0. Once saturated it holds, so long_tick fires only on the single
    // increment that lands on the all-ones value. Any path to ZERO, including
    // a disable, clears the counter.
    always_comb begin
      lp_next   = '0;
      long_next = 1'b0;
      if ((state_next == ONE) && (state != ONE)) begin
        lp_next = '0;
      end else if (level_next) begin
        if (lp_cnt != '1) begin
          lp_next   = lp_inc;
          long_next = (lp_inc == '1);
        end else begin
          lp_next = lp_cnt;
        end
      end
    end

    assign long_tick[i] = long_q;
`endif

  end

  assign any_tick = (|rise_tick) | (|fall_tick);

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
//
// Purpose:
//   Self-checking bench for debounce_bank with CH=2, N=3 (8-edge settle) and,
//   when DEBOUNCE_BANK_LONGPRESS_EN is defined, LP_N=4. A behavioural model
//   counts consecutive samples that differ from the debounced level and
//   flips the level when that run reaches 2^N. Expected outputs are pushed to
//   a scoreboard queue as each input vector is driven and popped after the
//   following clock edge. Directed phases also check the latencies and
//   corner cases (glitch, disable, simultaneous ticks, mid-wait reset).
// -----------------------------------------------------------------------------
module tb_debounce_bank;

  localparam int CH     = 2;
  localparam int N      = 3;
  localparam int LP_N   = 4;
  localparam int SETTLE = 1 << N;
  localparam int LP_MAX = (1 << LP_N) - 1;

  logic          clk;
  logic          reset;
  logic [CH-1:0] sw;
  logic [CH-1:0] en;
  logic [CH-1:0] db_level;
  logic [CH-1:0] rise_tick;
  logic [CH-1:0] fall_tick;
  logic          any_tick;
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
  logic [CH-1:0] long_tick;
`endif

  debounce_bank #(
    .CH   (CH),
    .N    (N),
    .LP_N (LP_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .en        (en),
    .db_level  (db_level),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .any_tick  (any_tick)
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    ,
    .long_tick (long_tick)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [CH-1:0] db;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] lng;
    logic          any;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [CH-1:0] m_level;
  int            m_run [CH];
  int            m_lp  [CH];

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_level = '0;
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0;
      m_lp[i]  = 0;
    end
  endtask

  // Drive one input vector, advance the model by one edge, queue the expected
  // outputs and step past the edge.
  task automatic applyStimulus(input logic [CH-1:0] sw_v, input logic [CH-1:0] en_v, input string tag);
    exp_t e;
    int   prev_run;
    sw     = sw_v;
    en     = en_v;
    e.tag  = tag;
    e.rise = '0;
    e.fall = '0;
    e.lng  = '0;
    for (int i = 0; i < CH; i++) begin
      if (!en_v[i]) begin
        m_level[i] = 1'b0;
        m_run[i]   = 0;
        m_lp[i]    = 0;
      end else begin
        prev_run = m_run[i];
        if (sw_v[i] != m_level[i]) m_run[i] = m_run[i] + 1;
        else m_run[i] = 0;
        if (m_run[i] == SETTLE) begin
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
          m_lp[i]    = 0;
          if (m_level[i]) e.rise[i] = 1'b1;
          else e.fall[i] = 1'b1;
        end else if (m_level[i]) begin
          if (prev_run > 0 && m_run[i] == 0) begin
            m_lp[i] = 0;
          end else if (m_lp[i] < LP_MAX) begin
            m_lp[i] = m_lp[i] + 1;
            if (m_lp[i] == LP_MAX) e.lng[i] = 1'b1;
          end
        end
      end
    end
    e.db  = m_level;
    e.any = (|e.rise) | (|e.fall);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    checkVal({e.tag, "/db_level"},  db_level,  e.db);
    checkVal({e.tag, "/rise_tick"}, rise_tick, e.rise);
    checkVal({e.tag, "/fall_tick"}, fall_tick, e.fall);
    checkVal({e.tag, "/any_tick"},  any_tick,  e.any);
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    checkVal({e.tag, "/long_tick"}, long_tick, e.lng);
`endif
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "/db_level"},  db_level,  '0);
    checkVal({tag, "/rise_tick"}, rise_tick, '0);
    checkVal({tag, "/fall_tick"}, fall_tick, '0);
    checkVal({tag, "/any_tick"},  any_tick,  '0);
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    checkVal({tag, "/long_tick"}, long_tick, '0);
`endif
  endtask

  initial begin
    int            rise_at;
    int            fall_at;
    int            long_at;
    int            long_cnt;
    int            any_cnt;
    int            early;
    logic [CH-1:0] rise_seen;
    logic [CH-1:0] sw_r;
    logic [CH-1:0] en_r;

    reset = 1'b1;
    sw    = '0;
    en    = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset_state");
    reset = 1'b0;

    // Channel 0 rises and is held; channel 1 stays low.
    $display("[TB] phase: single rise and hold");
    rise_at  = -1;
    long_at  = -1;
    long_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(2'b01, 2'b11, "hold_rise");
      checkOutput();
      if (rise_tick[0] && rise_at < 0) rise_at = k;
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
      if (long_tick[0]) begin
        long_cnt++;
        if (long_at < 0) long_at = k;
      end
`endif
    end
    checkVal("rise_latency", rise_at, SETTLE);
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    checkVal("long_after_rise", long_at - rise_at, LP_MAX);
    checkVal("long_pulse_count", long_cnt, 1);
`endif

    $display("[TB] phase: release");
    fall_at = -1;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(2'b00, 2'b11, "release");
      checkOutput();
      if (fall_tick[0] && fall_at < 0) fall_at = k;
    end
    checkVal("fall_latency", fall_at, SETTLE);

    // Five high samples, one low glitch, then a steady high.
    $display("[TB] phase: glitch during wait");
    early = 0;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(2'b01, 2'b11, "glitch_pre");
      checkOutput();
      if (rise_tick[0]) early++;
    end
    applyStimulus(2'b00, 2'b11, "glitch_low");
    checkOutput();
    if (rise_tick[0]) early++;
    rise_at = -1;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(2'b01, 2'b11, "glitch_post");
      checkOutput();
      if (rise_tick[0] && rise_at < 0) rise_at = k;
    end
    checkVal("glitch_no_early_rise", early, 0);
    checkVal("glitch_rise_latency", rise_at, SETTLE);

    // Channel 0 sits in ONE; disabling it must drop the level silently.
    $display("[TB] phase: disable while high");
    early = 0;
    applyStimulus(2'b01, 2'b10, "disable");
    checkOutput();
    checkVal("disable_db0_next", db_level[0], 1'b0);
    if (fall_tick[0]) early++;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(2'b01, 2'b10, "disable_hold");
      checkOutput();
      if (fall_tick[0]) early++;
    end
    checkVal("disable_no_fall", early, 0);
    applyStimulus(2'b00, 2'b10, "disable_low");
    checkOutput();
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(2'b00, 2'b11, "reenable");
      checkOutput();
    end

    $display("[TB] phase: simultaneous rise");
    any_cnt   = 0;
    rise_seen = '0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(2'b11, 2'b11, "both_rise");
      checkOutput();
      if (any_tick) begin
        any_cnt++;
        rise_seen = rise_tick;
      end
    end
    checkVal("both_any_count", any_cnt, 1);
    checkVal("both_rise_bits", rise_seen, 2'b11);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(2'b00, 2'b11, "both_fall");
      checkOutput();
    end

    // Channel 1 high, channel 0 four edges into its wait, then reset.
    $display("[TB] phase: reset mid-wait");
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(2'b10, 2'b11, "ch1_up");
      checkOutput();
    end
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(2'b11, 2'b11, "ch0_wait");
      checkOutput();
    end
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("reset_immediate");
    modelReset();
    @(posedge clk);
    #1;
    checkAllZero("reset_held");
    reset     = 1'b0;
    rise_at   = -1;
    rise_seen = '0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(2'b11, 2'b11, "post_reset");
      checkOutput();
      if (any_tick && rise_at < 0) begin
        rise_at   = k;
        rise_seen = rise_tick;
      end
    end
    checkVal("post_reset_latency", rise_at, SETTLE);
    checkVal("post_reset_rise_bits", rise_seen, 2'b11);

    // Slowly varying random inputs with occasional disables.
    $display("[TB] phase: random");
    sw_r = 2'b11;
    for (int k = 1; k <= 200; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 9) == 0) sw_r[i] = ~sw_r[i];
        en_r[i] = ($urandom_range(0, 39) != 0);
      end
      applyStimulus(sw_r, en_r, "random");
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
